// File: rtl/branch_resolver_if.sv
// rtl/branch_resolver_if.sv - ID capture, WB outcome and predictor-update bundle for branch_resolver
interface branch_resolver_if #(
  parameter int hist_reg_width = 4
);
  logic                      advance;
  logic                      id_valid;
  logic [3:0]                opcode_id;
  logic [15:0]               PC_id;
  logic                      predict_taken;
  logic [hist_reg_width-1:0] branch_hist_id;
  logic [15:0]               pred_target_id;
  logic                      actual_taken;
  logic [15:0]               actual_target;

  logic                      flush;
  logic [15:0]               redirect_pc;
  logic                      update_valid;
  logic [15:0]               PC_wb;
  logic [hist_reg_width-1:0] branch_hist_wb;
  logic                      taken_wb;
  logic [15:0]               branch_count;
  logic [15:0]               mispredict_count;

  // Pipeline side: drives ID capture and WB outcome, consumes resolution results.
  modport master (
    output advance, id_valid, opcode_id, PC_id, predict_taken, branch_hist_id,
           pred_target_id, actual_taken, actual_target,
    input  flush, redirect_pc, update_valid, PC_wb, branch_hist_wb, taken_wb,
           branch_count, mispredict_count
  );

  modport slave (
    input  advance, id_valid, opcode_id, PC_id, predict_taken, branch_hist_id,
           pred_target_id, actual_taken, actual_target,
    output flush, redirect_pc, update_valid, PC_wb, branch_hist_wb, taken_wb,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - gshare branch resolution: EX/MEM/WB shadow slots, flush/redirect, predictor update
module branch_resolver #(
  parameter int hist_reg_width = 4
) (
  input  logic              clk,
  input  logic              reset,
  branch_resolver_if.slave  bus
);

  localparam logic [3:0] OP_BR = 4'b0000;

  typedef struct packed {
    logic                      valid;
    logic [15:0]               pc;
    logic [hist_reg_width-1:0] hist;
    logic                      pred_taken;
    logic [15:0]               pred_target;
  } slot_t;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t state_q, state_d;
  slot_t  ex_q, mem_q, wb_q;
  slot_t  ex_d, mem_d, wb_d;

  logic                      resolve;
  logic                      dir_miss;
  logic                      tgt_miss;
  logic                      mispredict;
  logic [15:0]               redirect_d;

  logic                      flush_q;
  logic [15:0]               redirect_pc_q;
  logic                      update_valid_q;
  logic [15:0]               pc_wb_q;
  logic [hist_reg_width-1:0] branch_hist_wb_q;
  logic                      taken_wb_q;
  logic [15:0]               branch_count_q;
  logic [15:0]               mispredict_count_q;

  always_comb begin
    resolve    = bus.advance & wb_q.valid;
    dir_miss   = wb_q.pred_taken != bus.actual_taken;
    tgt_miss   = wb_q.pred_taken & bus.actual_taken & (wb_q.pred_target != bus.actual_target);
    mispredict = resolve & (dir_miss | tgt_miss);
    redirect_d = bus.actual_taken ? bus.actual_target : wb_q.pc + 16'd2;

    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (bus.advance) begin
      wb_d              = mem_q;
      mem_d             = ex_q;
      ex_d.valid        = bus.id_valid & (bus.opcode_id == OP_BR);
      ex_d.pc           = bus.PC_id;
      ex_d.hist         = bus.branch_hist_id;
      ex_d.pred_taken   = bus.predict_taken;
      ex_d.pred_target  = bus.pred_target_id;
      // Everything younger than the mispredicted branch is wrong-path.
      if (mispredict) begin
        wb_d.valid  = 1'b0;
        mem_d.valid = 1'b0;
        ex_d.valid  = 1'b0;
      end
    end
    if (state_q == S_FLUSH) begin
      ex_d.valid = 1'b0;
    end

    state_d = mispredict ? S_FLUSH : S_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_RUN;
      ex_q               <= '0;
      mem_q              <= '0;
      wb_q               <= '0;
      flush_q            <= 1'b0;
      redirect_pc_q      <= '0;
      update_valid_q     <= 1'b0;
      pc_wb_q            <= '0;
      branch_hist_wb_q   <= '0;
      taken_wb_q         <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q        <= state_d;
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      wb_q           <= wb_d;
      update_valid_q <= resolve;
      flush_q        <= mispredict;
      if (resolve) begin
        redirect_pc_q    <= redirect_d;
        pc_wb_q          <= wb_q.pc;
        branch_hist_wb_q <= wb_q.hist;
        taken_wb_q       <= bus.actual_taken;
        if (branch_count_q != 16'hFFFF) begin
          branch_count_q <= branch_count_q + 16'd1;
        end
      end
      if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
        mispredict_count_q <= mispredict_count_q + 16'd1;
      end
    end
  end

  assign bus.flush            = flush_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.update_valid     = update_valid_q;
  assign bus.PC_wb            = pc_wb_q;
  assign bus.branch_hist_wb   = branch_hist_wb_q;
  assign bus.taken_wb         = taken_wb_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed and randomized check of branch_resolver against a queue-based model
module tb_branch_resolver;

  localparam int         HW    = 4;
  localparam logic [3:0] OP_BR = 4'b0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolver_if #(.hist_reg_width(HW)) bus();
  branch_resolver #(.hist_reg_width(HW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit          v;
    bit [15:0]   pc;
    bit [HW-1:0] h;
    bit          pt;
    bit [15:0]   tg;
  } ent_t;

  // Model: queue of the three in-flight shadow entries, youngest at the front.
  ent_t        pipe[$];
  bit          in_flush;
  bit          e_upd, e_flush, e_taken;
  bit [15:0]   e_redir, e_pc, e_bcnt, e_mcnt;
  bit [HW-1:0] e_hist;

  int total = 0;
  int bad   = 0;
  int upd_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z = '{default: 0};
    pipe = {};
    repeat (3) pipe.push_back(z);
    in_flush = 0;
    e_upd = 0; e_flush = 0; e_taken = 0;
    e_redir = 0; e_pc = 0; e_bcnt = 0; e_mcnt = 0; e_hist = 0;
  endtask

  task automatic model_step();
    ent_t old, nw;
    bit   mis;
    if (reset) begin
      model_reset();
      return;
    end
    e_upd = 0; e_flush = 0; mis = 0;
    if (bus.advance) begin
      old = pipe.pop_back();
      if (old.v) begin
        e_upd   = 1;
        e_pc    = old.pc;
        e_hist  = old.h;
        e_taken = bus.actual_taken;
        if (e_bcnt != 16'hFFFF) e_bcnt++;
        mis = (old.pt != bus.actual_taken) ||
              (old.pt && bus.actual_taken && old.tg != bus.actual_target);
        if (mis) begin
          e_flush = 1;
          e_redir = bus.actual_taken ? bus.actual_target : 16'(old.pc + 16'd2);
          if (e_mcnt != 16'hFFFF) e_mcnt++;
        end
      end
      nw.v  = bus.id_valid && (bus.opcode_id == OP_BR) && !in_flush;
      nw.pc = bus.PC_id; nw.h = bus.branch_hist_id;
      nw.pt = bus.predict_taken; nw.tg = bus.pred_target_id;
      pipe.push_front(nw);
      if (mis) foreach (pipe[i]) pipe[i].v = 0;
    end
    in_flush = mis;
  endtask

  task automatic compare();
    chk("update_valid", bus.update_valid, e_upd);
    chk("flush", bus.flush, e_flush);
    if (e_flush) chk("redirect_pc", bus.redirect_pc, e_redir);
    chk("PC_wb", bus.PC_wb, e_pc);
    chk("branch_hist_wb", bus.branch_hist_wb, e_hist);
    chk("taken_wb", bus.taken_wb, e_taken);
    chk("branch_count", bus.branch_count, e_bcnt);
    chk("mispredict_count", bus.mispredict_count, e_mcnt);
    if (bus.update_valid) upd_seen++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle_in();
    bus.id_valid = 0; bus.opcode_id = 4'h1; bus.PC_id = 0;
    bus.predict_taken = 0; bus.branch_hist_id = 0; bus.pred_target_id = 0;
  endtask

  task automatic run_br(input logic [15:0] pc, input logic pt, input logic [15:0] tg,
                        input logic at, input logic [15:0] atg);
    bus.advance = 1; bus.id_valid = 1; bus.opcode_id = OP_BR; bus.PC_id = pc;
    bus.predict_taken = pt; bus.pred_target_id = tg; bus.branch_hist_id = pc[HW:1];
    bus.actual_taken = at; bus.actual_target = atg;
    tick();
    idle_in();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1; bus.advance = 0; bus.actual_taken = 0; bus.actual_target = 0;
    idle_in();
    model_reset();
    tick();
    chk("reset_flush", bus.flush, 0);
    chk("reset_redirect", bus.redirect_pc, 0);
    chk("reset_bcnt", bus.branch_count, 0);
    reset = 0;
    tick();

    run_br(16'h3000, 1, 16'h3010, 1, 16'h3010);
    chk("ok_upd", bus.update_valid, 1);
    chk("ok_pc", bus.PC_wb, 16'h3000);
    chk("ok_taken", bus.taken_wb, 1);
    chk("ok_flush", bus.flush, 0);
    chk("ok_bcnt", bus.branch_count, 1);

    // Direction mispredict with two younger BRs behind it.
    upd_seen = 0;
    bus.advance = 1; bus.actual_taken = 1; bus.actual_target = 16'h4020;
    bus.id_valid = 1; bus.opcode_id = OP_BR; bus.predict_taken = 0;
    bus.PC_id = 16'h4000; bus.pred_target_id = 16'h4002; tick();
    bus.predict_taken = 1; bus.PC_id = 16'h4004; bus.pred_target_id = 16'h0100; tick();
    bus.PC_id = 16'h4008; tick();
    idle_in(); tick();
    chk("dir_flush", bus.flush, 1);
    chk("dir_redirect", bus.redirect_pc, 16'h4020);
    chk("dir_mcnt", bus.mispredict_count, 1);
    tick();
    chk("dir_flush_pulse", bus.flush, 0);
    repeat (6) tick();
    chk("dir_squash_upd", upd_seen, 1);

    run_br(16'hFFFE, 1, 16'h1234, 0, 16'h1234);
    chk("wrap_flush", bus.flush, 1);
    chk("wrap_redirect", bus.redirect_pc, 16'h0000);
    tick();

    run_br(16'h4F00, 1, 16'h5000, 1, 16'h5008);
    chk("tgt_flush", bus.flush, 1);
    chk("tgt_redirect", bus.redirect_pc, 16'h5008);
    tick();

    // Stall with a valid entry parked in WB.
    upd_seen = 0;
    bus.advance = 1; bus.id_valid = 1; bus.opcode_id = OP_BR; bus.PC_id = 16'h6000;
    bus.predict_taken = 0; bus.actual_taken = 0; tick();
    idle_in(); tick(); tick();
    bus.advance = 0; repeat (4) tick();
    chk("stall_no_upd", upd_seen, 0);
    bus.advance = 1; tick();
    chk("stall_one_upd", upd_seen, 1);
    repeat (2) tick();
    chk("stall_total_upd", upd_seen, 1);

    run_br(16'h7000, 0, 16'h7100, 1, 16'h7100);
    chk("rst_pre_flush", bus.flush, 1);
    reset = 1; tick(); reset = 0;
    chk("rst_flush", bus.flush, 0);
    chk("rst_bcnt", bus.branch_count, 0);
    chk("rst_mcnt", bus.mispredict_count, 0);
    repeat (4) tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      bus.advance = ($urandom_range(0, 9) < 8);
      bus.id_valid = ($urandom_range(0, 9) < 7);
      bus.opcode_id = ($urandom_range(0, 1) == 0) ? OP_BR : 4'($urandom_range(0, 15));
      bus.PC_id = {15'($urandom), 1'b0};
      bus.predict_taken = 1'($urandom);
      bus.branch_hist_id = HW'($urandom);
      bus.pred_target_id = ($urandom_range(0, 3) == 0) ? 16'hFFFE : {15'($urandom), 1'b0};
      if (pipe[2].v && $urandom_range(0, 9) < 6) begin
        bus.actual_taken = pipe[2].pt;
        bus.actual_target = ($urandom_range(0, 4) == 0) ? {15'($urandom), 1'b0} : pipe[2].tg;
        if (!pipe[2].pt) bus.actual_target = {15'($urandom), 1'b0};
      end else begin
        bus.actual_taken = 1'($urandom);
        bus.actual_target = {15'($urandom), 1'b0};
      end
      tick();
    end
    reset = 0;

    // Mispredict counter saturation, preloaded just below the ceiling.
    reset = 1; bus.advance = 0; idle_in(); tick(); reset = 0;
    force dut.mispredict_count_q = 16'hFFFE;
    release dut.mispredict_count_q;
    e_mcnt = 16'hFFFE;
    run_br(16'h8000, 0, 16'h8010, 1, 16'h8010);
    chk("sat_reach", bus.mispredict_count, 16'hFFFF);
    tick();
    run_br(16'h8100, 0, 16'h8110, 1, 16'h8110);
    chk("sat_hold_flush", bus.flush, 1);
    chk("sat_hold", bus.mispredict_count, 16'hFFFF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolution side of the gshare branch predictor in the LC-3b pipeline. Captures each predicted BR at ID with its PC, history snapshot, predicted direction and predicted target, and shadows it through EX and MEM into WB. At WB it compares against the actual outcome, then issues a one-cycle flush with the redirect PC and drives the predictor's WB-side update signals. It also keeps saturating branch and mispredict counters for performance analysis.

## Interface
- hist_reg_width, default 4: width of the global history snapshot; must match the predictor.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- advance  in  1  pipeline moves one stage this cycle; 0 means all stages stall.
- id_valid  in  1  ID holds a valid instruction.
- opcode_id  in  4  ID opcode; an entry is captured only when this is op_br.
- PC_id  in  16  PC of the ID instruction.
- predict_taken  in  1  predictor direction for the ID instruction.
- branch_hist_id  in  hist_reg_width  predictor history snapshot at ID.
- pred_target_id  in  16  target fetch used if predicted taken.
- actual_taken  in  1  resolved direction of the instruction in WB.
- actual_target  in  16  resolved target of the instruction in WB.
- flush  out  1  one-cycle pulse; kill IF/ID/EX/MEM and load redirect_pc.
- redirect_pc  out  16  correct next PC; valid while flush=1.
- update_valid  out  1  one-cycle pulse; predictor may write its counter/history.
- PC_wb  out  16  PC of the resolved branch.
- branch_hist_wb  out  hist_reg_width  history snapshot of the resolved branch.
- taken_wb  out  1  resolved direction.
- branch_count  out  16  resolved branches, saturating.
- mispredict_count  out  16  mispredicts, saturating.

## Operation
- Shadow pipeline: three slots (EX, MEM, WB). Each slot holds valid, pc, hist, pred_taken and pred_target.
- When advance=1:
  - The WB slot retires, MEM moves to WB, and EX moves to MEM.
  - EX loads {id_valid & opcode_id==op_br, PC_id, branch_hist_id, predict_taken, pred_target_id}.
- When advance=0, all slots hold.
- Resolution happens only when advance=1 and the WB slot is valid. Mispredict is true if:
  - pred_taken != actual_taken, or
  - pred_taken = actual_taken = 1 and pred_target != actual_target.
- redirect_pc = actual_taken ? actual_target : pc + 16'd2. Arithmetic is modulo 2^16, so 0xFFFE + 2 gives 0x0000.
- On mispredict, the same edge that retires WB also clears the valid bits of the values being loaded into MEM and EX. Younger work is therefore squashed and no wrong-path branch can resolve later.
- FSM states:
  - RUN to FLUSH on a mispredict.
  - FLUSH to RUN unconditionally after one cycle.
  - In FLUSH, the EX capture is forced invalid regardless of advance, because the ID contents are wrong-path.
  - A second mispredict cannot occur in FLUSH, since all slots are invalid.
- Counters: branch_count increments on every resolution and mispredict_count on every mispredict. Both saturate at 0xFFFF and are cleared only by reset.

## Timing
- Reset (synchronous): all slot valids = 0, FSM = RUN, and every output = 0 (flush, redirect_pc, update_valid, PC_wb, branch_hist_wb, taken_wb, both counters).
- All outputs are registered. A resolution at edge N drives its outputs during cycle N+1.
- update_valid is high for exactly one cycle per resolution, correct or not. PC_wb, branch_hist_wb and taken_wb hold their values until the next resolution.
- flush is high for exactly one cycle per mispredict. It is asserted in the same cycle as the matching update_valid, and redirect_pc is valid alongside it.
- Latency from ID capture to flush: 3 advancing edges plus 1 register cycle. Stall cycles add one-for-one.
- Stall while a valid entry sits in WB: no resolution, no update, and no duplicate counting.
- Reset asserted during FLUSH or with entries in flight: everything is cleared on that edge, and no flush or update appears afterwards.
- Back-to-back correct branches: one update_valid per advancing cycle, with no bubbles required.

## Test plan
- Correct prediction: BR at PC 0x3000, predict_taken=1, target 0x3010, actual taken to 0x3010, three advances. Required: update_valid=1, PC_wb=0x3000, taken_wb=1, flush=0, branch_count=1.
- Direction mispredict: predict_taken=0 at PC 0x4000, actual taken to 0x4020. Required: flush=1 for one cycle, redirect_pc=0x4020, mispredict_count=1. The younger BRs in EX and MEM never produce update_valid.
- Not-taken mispredict with wrap-around: predict_taken=1 at PC 0xFFFE, actual not taken. Required: redirect_pc=0x0000.
- Target mispredict: both taken, pred_target 0x5000, actual_target 0x5008. Required: flush=1, redirect_pc=0x5008.
- Stall: hold advance=0 for 4 cycles with a BR in WB. Required: no update_valid during the stall, and exactly one update_valid after advance returns to 1.
- Reset and saturation:
  - Reset the cycle after a mispredict. Required: flush=0 and counters=0 next cycle.
  - Preload mispredict_count to 0xFFFF via 65535 mispredicts (or force), then one more mispredict. Required: stays at 0xFFFF.
